// File: rtl/ififo_sram_fetch.sv
// ----------------------------------------------------------------------------
// ififo_sram_fetch
// Core-side reader for the input SRAM. After start it walks the SRAM in kij
// order: for each kernel position it reads the row weight words
// (kij*row + r) and then all len_nij activation words (act_base + n). Every
// word goes out on a valid/ready stream tagged with its phase and kij.
// A 2-entry output buffer plus at most one in-flight read lets the block
// sustain one word per cycle while never losing a word under backpressure.
//
// Ports
//   clk           in   clock
//   reset         in   synchronous, active-high reset
//   start         in   begin a pass (only looked at while idle)
//   sram_cen      out  SRAM chip enable, active low (low = read this cycle)
//   sram_wen      out  SRAM write enable, tied high (read only)
//   sram_a        out  SRAM read address
//   sram_q        in   SRAM read data, valid the cycle after sram_cen=0
//   out_data      out  stream word (head of the output buffer)
//   out_valid     out  out_data is valid
//   out_ready     in   consumer accepts when out_valid & out_ready
//   out_is_weight out  1 = weight word, 0 = activation word
//   out_kij       out  kernel position of the head word
//   busy          out  pass in progress
//   done          out  one-cycle pulse after the last word is accepted
// ----------------------------------------------------------------------------
module ififo_sram_fetch #(
    parameter int bw       = 4,
    parameter int row      = 8,
    parameter int len_kij  = 9,
    parameter int len_nij  = 36,
    parameter int act_base = 72,
    parameter int addr_w   = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                sram_cen,
    output logic                sram_wen,
    output logic [addr_w-1:0]   sram_a,
    input  logic [row*bw-1:0]   sram_q,
    output logic [row*bw-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_is_weight,
    output logic [3:0]          out_kij,
    output logic                busy,
    output logic                done
);

    localparam int DW      = row * bw;
    localparam int EW      = DW + 5;               // {data, is_weight, kij[3:0]}
    localparam int IDX_MAX = (row > len_nij) ? row : len_nij;
    localparam int IDX_W   = $clog2(IDX_MAX);

    // The activation window must fit in the address space.
    if (act_base + len_nij > (1 << addr_w)) begin : g_addr_width_check
        $error("ififo_sram_fetch: act_base + len_nij does not fit in addr_w bits");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_ALOAD = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_kij;
    logic [3:0]         w_kij_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_busy;
    logic               r_done;

    logic [EW-1:0]      r_mem [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;
    logic               r_inflight;
    logic               r_if_isw;
    logic [3:0]         r_if_kij;

    logic               w_pop;
    logic               w_push;
    logic               w_loading;
    logic [2:0]         w_occ;
    logic               w_issue;
    logic [1:0]         w_count_nxt;
    logic [addr_w-1:0]  w_addr;
    logic [EW-1:0]      w_head;

    // Issue gating: occupancy is what the buffer will hold once this cycle's
    // pop and the outstanding read have settled; a new read needs a free slot.
    always_comb begin
        w_pop       = (r_count != 2'd0) && out_ready;
        w_push      = r_inflight;
        w_loading   = (r_state == S_WLOAD) || (r_state == S_ALOAD);
        w_occ       = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
        w_issue     = w_loading && (w_occ < 3'd2);
        w_count_nxt = 2'(3'(r_count) + 3'(w_push) - 3'(w_pop));
    end

    // Read address for the current walk position.
    always_comb begin
        w_addr = '0;
        case (r_state)
            S_WLOAD: w_addr = addr_w'(r_kij) * addr_w'(row) + addr_w'(r_idx);
            S_ALOAD: w_addr = addr_w'(act_base) + addr_w'(r_idx);
            default: w_addr = '0;
        endcase
    end

    // Walk sequencer: next state and next counter values.
    always_comb begin
        w_state_nxt = r_state;
        w_kij_nxt   = r_kij;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WLOAD;
                    w_kij_nxt   = 4'd0;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WLOAD: begin
                if (w_issue) begin
                    if (r_idx == IDX_W'(row - 1)) begin
                        w_state_nxt = S_ALOAD;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_state_nxt = S_WLOAD;
                end
            end
            S_ALOAD: begin
                if (w_issue) begin
                    if (r_idx == IDX_W'(len_nij - 1)) begin
                        w_idx_nxt = '0;
                        if (r_kij < 4'(len_kij - 1)) begin
                            w_state_nxt = S_WLOAD;
                            w_kij_nxt   = r_kij + 4'd1;
                        end else begin
                            w_state_nxt = S_DRAIN;
                        end
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_state_nxt = S_ALOAD;
                end
            end
            S_DRAIN: begin
                // Looking at next-cycle occupancy lets done rise the cycle
                // right after the final handshake; an empty next buffer also
                // implies nothing was in flight.
                if (w_count_nxt == 2'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_kij_nxt   = 4'd0;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_kij_nxt   = 4'd0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Sequencer state, walk counters and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_kij   <= 4'd0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kij   <= w_kij_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= (w_state_nxt == S_WLOAD) || (w_state_nxt == S_ALOAD) ||
                       (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // In-flight read tracking and the 2-entry output buffer. Tags are taken
    // at issue time so they stay aligned with the data returning a cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_if_isw   <= 1'b0;
            r_if_kij   <= 4'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {sram_q, r_if_isw, r_if_kij};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            r_inflight <= w_issue;
            r_if_isw   <= (r_state == S_WLOAD);
            r_if_kij   <= r_kij;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign out_data      = w_head[EW-1:5];
    assign out_is_weight = w_head[4];
    assign out_kij       = w_head[3:0];
    assign out_valid     = (r_count != 2'd0);

    assign sram_cen = ~w_issue;
    assign sram_wen = 1'b1;
    assign sram_a   = w_addr;

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_ififo_sram_fetch.sv
// ----------------------------------------------------------------------------
// Testbench for ififo_sram_fetch. A behavioural SRAM answers reads one cycle
// after sram_cen=0. The expected stream is derived from the walk order
// (per kij: row weight words, then len_nij activation words) over the
// preloaded memory image; each scenario task compares the stream against it.
// ----------------------------------------------------------------------------
module tb_ififo_sram_fetch;

    localparam int BW       = 4;
    localparam int ROW      = 8;
    localparam int LEN_KIJ  = 9;
    localparam int LEN_NIJ  = 36;
    localparam int ACT_BASE = 72;
    localparam int ADDR_W   = 7;
    localparam int DW       = ROW * BW;
    localparam int N_WORDS  = LEN_KIJ * (ROW + LEN_NIJ);
    localparam int LIMIT    = 3000;

    logic              clk;
    logic              reset;
    logic              start;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [DW-1:0]     sram_q;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_is_weight;
    logic [3:0]        out_kij;
    logic              busy;
    logic              done;

    logic [DW-1:0] mem [128];
    logic [DW-1:0] exp_data [N_WORDS];
    logic          exp_isw  [N_WORDS];
    logic [3:0]    exp_kij  [N_WORDS];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: registered read.
    always @(posedge clk) begin
        if (sram_cen === 1'b0) sram_q <= mem[sram_a];
    end

    ififo_sram_fetch #(
        .bw(BW), .row(ROW), .len_kij(LEN_KIJ), .len_nij(LEN_NIJ),
        .act_base(ACT_BASE), .addr_w(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_q(sram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_is_weight(out_is_weight), .out_kij(out_kij),
        .busy(busy), .done(done)
    );

    task automatic load_mem(input bit rnd);
        for (int a = 0; a < 128; a++) mem[a] = rnd ? DW'($urandom) : DW'(a);
    endtask

    // Golden stream order over the current memory image.
    task automatic build_expected();
        int w;
        w = 0;
        for (int kk = 0; kk < LEN_KIJ; kk++) begin
            for (int r = 0; r < ROW; r++) begin
                exp_data[w] = mem[kk * ROW + r]; exp_isw[w] = 1'b1; exp_kij[w] = 4'(kk); w++;
            end
            for (int n = 0; n < LEN_NIJ; n++) begin
                exp_data[w] = mem[ACT_BASE + n]; exp_isw[w] = 1'b0; exp_kij[w] = 4'(kk); w++;
            end
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            1:       return ((k % 4) == 0) || ((k % 4) == 3);
            2:       return 1'($urandom_range(0, 1));
            3:       return !((k >= 177) && (k <= 196));
            default: return 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (sram_cen !== 1'b1) $display("FAIL reset_cen: got %b exp 1", sram_cen); else n_pass++;
        n_checks++; if (sram_wen !== 1'b1) $display("FAIL reset_wen: got %b exp 1", sram_wen); else n_pass++;
        n_checks++; if (sram_a !== 7'd0) $display("FAIL reset_a: got %h exp 0", sram_a); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'd0) $display("FAIL reset_data: got %h exp 0", out_data); else n_pass++;
        n_checks++; if (out_is_weight !== 1'b0 || out_kij !== 4'd0)
            $display("FAIL reset_tags: got isw=%b kij=%0d exp 0/0", out_is_weight, out_kij); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_status: got busy=%b done=%b exp 0/0", busy, done); else n_pass++;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || sram_cen !== 1'b1)
            $display("FAIL idle_after_reset: got busy=%b cen=%b exp 0/1", busy, sram_cen); else n_pass++;
    endtask

    // One full pass. mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready,
    // 3 ready=0 for 20 cycles at the kij 3->4 boundary. repulse re-pulses start
    // after 50 accepted words.
    task automatic test_stream(input int mode, input bit repulse, input bit rnd_data);
        int k, got, dones, done_k;
        bit pulsed, held;
        logic [DW-1:0] h_data;
        logic h_isw;
        logic [3:0] h_kij;
        load_mem(rnd_data);
        build_expected();
        got = 0; dones = 0; done_k = -1; pulsed = 0; held = 0;
        h_data = '0; h_isw = 1'b0; h_kij = 4'd0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; out_ready = ready_for(mode, 0);
        k = 0;
        while (k < LIMIT) begin
            @(negedge clk);
            if (k == 0) begin
                n_checks++; if (busy !== 1'b1) $display("FAIL busy_after_start: got %b exp 1", busy); else n_pass++;
            end
            if (mode == 0 && k == 1) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL early_valid: got %b exp 0 at k=1", out_valid); else n_pass++;
            end
            if (mode == 0 && k == 2) begin
                n_checks++; if (out_valid !== 1'b1) $display("FAIL first_valid: got %b exp 1 at k=2", out_valid); else n_pass++;
            end
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== h_data || out_is_weight !== h_isw || out_kij !== h_kij)
                    $display("FAIL stall_stable k=%0d: got v=%b %h/%b/%0d exp 1 %h/%b/%0d",
                             k, out_valid, out_data, out_is_weight, out_kij, h_data, h_isw, h_kij);
                else n_pass++;
            end
            if (mode == 3 && k == 176) begin
                n_checks++; if (sram_cen !== 1'b0 || sram_a !== 7'd32)
                    $display("FAIL boundary_issue: got cen=%b a=%0d exp 0/32", sram_cen, sram_a); else n_pass++;
            end
            if (mode == 3 && k >= 177 && k <= 196) begin
                n_checks++; if (sram_cen !== 1'b1 || out_data !== exp_data[175])
                    $display("FAIL boundary_stall k=%0d: got cen=%b head=%h exp 1/%h", k, sram_cen, out_data, exp_data[175]);
                else n_pass++;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_checks++;
                if (got >= N_WORDS)
                    $display("FAIL extra_word: got word %0d data %h exp none", got, out_data);
                else if (out_data !== exp_data[got] || out_is_weight !== exp_isw[got] || out_kij !== exp_kij[got])
                    $display("FAIL word[%0d]: got %h/isw=%b/kij=%0d exp %h/isw=%b/kij=%0d", got,
                             out_data, out_is_weight, out_kij, exp_data[got], exp_isw[got], exp_kij[got]);
                else n_pass++;
                got++;
            end
            held = (out_valid === 1'b1) && (out_ready === 1'b0);
            h_data = out_data; h_isw = out_is_weight; h_kij = out_kij;
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    done_k = k;
                    n_checks++; if (busy !== 1'b0) $display("FAIL busy_with_done: got %b exp 0", busy); else n_pass++;
                    if (mode == 0) begin
                        n_checks++; if (k != 2 + N_WORDS) $display("FAIL done_time: got %0d exp %0d", k, 2 + N_WORDS); else n_pass++;
                    end
                end
            end
            if (dones > 0 && k >= done_k + 3) break;
            @(posedge clk); #1;
            k++;
            out_ready = ready_for(mode, k);
            start = repulse && (got == 50) && !pulsed;
            if (start) pulsed = 1;
        end
        start = 1'b0;
        n_checks++; if (k >= LIMIT) $display("FAIL timeout: got %0d cycles exp < %0d", k, LIMIT); else n_pass++;
        n_checks++; if (got != N_WORDS) $display("FAIL word_count: got %0d exp %0d", got, N_WORDS); else n_pass++;
        n_checks++; if (dones != 1) $display("FAIL done_count: got %0d exp 1", dones); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int dones;
        load_mem(1'b0);
        build_expected();
        @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (152) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_data[150])
            $display("FAIL abort_head: got v=%b %h exp 1 %h", out_valid, out_data, exp_data[150]); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (sram_cen !== 1'b1) $display("FAIL abort_cen: got %b exp 1", sram_cen); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_status: got busy=%b done=%b exp 0/0", busy, done); else n_pass++;
        @(posedge clk); #1 reset = 1'b0;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1) dones++;
        end
        n_checks++; if (dones != 0) $display("FAIL abort_quiet: got %0d active cycles exp 0", dones); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        load_mem(1'b0);
        test_reset();
        test_stream(0, 1'b0, 1'b0);
        test_stream(1, 1'b0, 1'b0);
        test_stream(3, 1'b0, 1'b0);
        test_reset_abort();
        test_stream(0, 1'b0, 1'b0);
        test_stream(0, 1'b1, 1'b0);
        test_stream(2, 1'b0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
